icache_req_arbiter_mc: RTL

//  N-channel tag-pipeline request arbiter; parametrised successor of the fixed 3-source (upstream/snoop/prefetch) arbiter.
//  Per-channel programmable priority, round-robin within a level, anti-starvation aging and a per-channel enable mask.

---
 rtl/icache_req_arbiter_mc_pkg.sv | 25 ++
 rtl/icache_rr_pick.sv | 34 +++
 rtl/icache_req_arbiter_mc.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/icache_req_arbiter_mc_pkg.sv
// Shared types, defaults and helpers for the icache tag-pipeline request arbiter.
package icache_req_arbiter_mc_pkg;

    localparam int ARB_CH_NUM       = 4;
    localparam int ARB_OPCODE_W     = 5;
    localparam int ARB_TXNID_W      = 8;
    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_PRIO_W       = 2;
    localparam int ARB_STARVE_LIMIT = 15;
    // Age counters are sized for the largest legal starvation limit (255).
    localparam int ARB_AGE_W        = 8;

    // Request record at the default widths.
    typedef struct packed {
        logic [ARB_OPCODE_W-1:0] opcode;
        logic [ARB_TXNID_W-1:0]  txnid;
        logic [ARB_ADDR_W-1:0]   addr;
    } arb_req_t;

    // Index width for an n-entry vector; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module icache_rr_pick
    import icache_req_arbiter_mc_pkg::*;
#(
    parameter int N = ARB_CH_NUM,
    localparam int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW:0] pos;
    logic        found;

    // Walk the request vector starting at ptr and grant the first hit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!found && req[pos[PW-1:0]]) begin
                grant[pos[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_req_arbiter_mc.sv
// N-channel tag-pipeline request arbiter: programmable priority, round-robin
// within a level, anti-starvation aging, per-channel enable, one output slot.
module icache_req_arbiter_mc
    import icache_req_arbiter_mc_pkg::*;
#(
    parameter int CH_NUM       = ARB_CH_NUM,
    parameter int OPCODE_W     = ARB_OPCODE_W,
    parameter int TXNID_W      = ARB_TXNID_W,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int PRIO_W       = ARB_PRIO_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    localparam int CH_W        = idx_w(CH_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            cfg_en,
    input  logic [CH_NUM*PRIO_W-1:0]     cfg_prio,
    input  logic [CH_NUM-1:0]            in_vld,
    output logic [CH_NUM-1:0]            in_rdy,
    input  logic [CH_NUM*OPCODE_W-1:0]   in_opcode,
    input  logic [CH_NUM*TXNID_W-1:0]    in_txnid,
    input  logic [CH_NUM*ADDR_W-1:0]     in_addr,
    output logic                         tag_req_vld,
    input  logic                         tagram_rdy,
    input  logic                         mshr_rdy,
    output logic [OPCODE_W-1:0]          tag_req_opcode,
    output logic [TXNID_W-1:0]           tag_req_txnid,
    output logic [ADDR_W-1:0]            tag_req_addr,
    output logic [CH_W-1:0]              tag_req_ch,
    output logic [CH_NUM-1:0]            urgent_vec
);

    localparam int AGE_W = ARB_AGE_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [TXNID_W-1:0]  txnid;
        logic [ADDR_W-1:0]   addr;
    } req_t;

    logic [CH_NUM-1:0] elig;
    logic [CH_NUM-1:0] urg_req;
    logic [CH_NUM-1:0] top_req;
    logic [CH_NUM-1:0] g_urg;
    logic [CH_NUM-1:0] g_top;
    logic [CH_NUM-1:0] grant;
    logic [PRIO_W-1:0] max_prio;
    logic              fire;
    logic              load;
    logic              any_grant;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_ptr_nxt;
    logic [AGE_W-1:0]  age [CH_NUM];
    req_t              win_req;
    req_t              slot;

    assign fire = tag_req_vld & tagram_rdy & mshr_rdy;
    assign load = ~tag_req_vld | fire;
    assign elig = in_vld & cfg_en;

    // Urgent flags and the highest priority level present among eligible channels.
    always_comb begin
        urgent_vec = '0;
        max_prio   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            urgent_vec[i] = (age[i] == AGE_MAX);
            if (elig[i] && (cfg_prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
                max_prio = cfg_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // Candidate sets for the two round-robin pickers.
    always_comb begin
        urg_req = elig & urgent_vec;
        top_req = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            top_req[i] = elig[i] && (cfg_prio[i*PRIO_W +: PRIO_W] == max_prio);
        end
    end

    icache_rr_pick #(.N(CH_NUM)) u_pick_urg (
        .req   (urg_req),
        .ptr   (rr_ptr),
        .grant (g_urg)
    );

    icache_rr_pick #(.N(CH_NUM)) u_pick_top (
        .req   (top_req),
        .ptr   (rr_ptr),
        .grant (g_top)
    );

    // Urgent channels pre-empt priority; no grant while the slot is stalled or in reset.
    always_comb begin
        grant = '0;
        if (load && !rst) begin
            grant = (|urg_req) ? g_urg : g_top;
        end
    end

    assign in_rdy    = grant;
    assign any_grant = |grant;

    // Winner index, its payload and the advanced round-robin pointer.
    always_comb begin
        win     = '0;
        win_req = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant[i]) begin
                win            = CH_W'(i);
                win_req.opcode = in_opcode[i*OPCODE_W +: OPCODE_W];
                win_req.txnid  = in_txnid[i*TXNID_W +: TXNID_W];
                win_req.addr   = in_addr[i*ADDR_W +: ADDR_W];
            end
        end
        if ((CH_NUM == 1) || (win == CH_W'(CH_NUM-1))) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = win + 1'b1;
        end
    end

    // Round-robin pointer moves past the winner on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Age counters: clear when idle/masked or granted, count losses to another channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small register array feeds urgent_vec, so it is reset like any other state.
            for (int i = 0; i < CH_NUM; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (!elig[i] || grant[i]) begin
                    age[i] <= '0;
                end else if (any_grant && (age[i] != AGE_MAX)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // Output slot: load on grant, empty on fire with no replacement, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_req_vld <= 1'b0;
            slot        <= '0;
            tag_req_ch  <= '0;
        end else if (any_grant) begin
            tag_req_vld <= 1'b1;
            slot        <= win_req;
            tag_req_ch  <= win;
        end else if (fire) begin
            tag_req_vld <= 1'b0;
        end
    end

    assign tag_req_opcode = slot.opcode;
    assign tag_req_txnid  = slot.txnid;
    assign tag_req_addr   = slot.addr;

    // A channel must keep its request up until it is accepted.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_proto
        a_vld_hold: assert property (@(posedge clk) disable iff (rst)
                                     (in_vld[i] && !in_rdy[i]) |=> in_vld[i])
            else $error("channel %0d dropped in_vld before in_rdy", i);
    end

endmodule
